divide_seq: RTL and testbench
=============================

// Module: divide_seq
// PURPOSE
// - Iterative restoring divider: the inverse of the calculator's combinational 16x16 multiplier.
// - Takes a 32-bit dividend (a full product width) and a 16-bit divisor.
// - Returns a 32-bit quotient and a 16-bit remainder after a fixed latency.
// - Sits in the ALU datapath beside the multiplier; the operation decoder drives it
//   with a start/done handshake.
// PARAMETERS
// - N_W  32  dividend and quotient width; also the number of iterations
// - D_W  16  divisor and remainder width; must satisfy D_W <= N_W
// PORTS
// - clk        in   1     single clock; all logic is on the rising edge
// - rst        in   1     synchronous, active-high reset
// - start      in   1     request a divide; sampled only when busy=0
// - dividend   in   N_W   numerator, captured on an accepted start
// - divisor    in   D_W   denominator, captured on an accepted start
// - busy       out  1     high while an iteration is in progress
// - done       out  1     one-cycle pulse; quotient/remainder/div_zero are valid
// - quotient   out  N_W   floor(dividend/divisor)
// - remainder  out  D_W   dividend mod divisor
// - div_zero   out  1     the last accepted operation had divisor==0
// BEHAVIOUR
// - Reset:
//   - Every output goes to 0 and the FSM goes to IDLE.
//   - Reset while in CALC aborts the operation; no done is issued for it.
// - FSM states: IDLE, CALC, FIN.
//   - IDLE: start=1 and divisor!=0 -> CALC. Latch the operands, clear the partial
//     remainder (D_W+1 bits), set count=N_W-1, busy<=1.
//   - IDLE: start=1 and divisor==0 -> FIN. Set quotient<=all ones, remainder<=0,
//     div_zero<=1. busy stays 0.
//   - CALC, each cycle:
//     - Shift the next dividend MSB into the partial remainder.
//     - Trial-subtract the divisor. If the result is >= 0, keep the difference and
//       shift 1 into the quotient; otherwise restore and shift 0.
//     - Decrement count. When count==0 -> FIN.
//   - FIN: done<=1 for exactly one cycle, busy<=0, -> IDLE. Results were written on
//     entry to FIN.
// - Timing:
//   - Start accepted at edge k: busy is high in cycles k+1..k+N_W.
//   - done is high in cycle k+N_W+1.
//   - Latency start->done is N_W+1 cycles (33 by default).
//   - The divide-by-zero path has done in cycle k+1.
// - Result hold: quotient, remainder and div_zero hold their values after done until the
//   next accepted start. div_zero clears on any accepted start with a nonzero divisor.
// - start while busy=1 or in FIN is ignored; operands may change freely during that time.
// - start held high continuously starts a new operation in the IDLE cycle after each done.
// - Arithmetic is unsigned only.
// - Results are exact: quotient*divisor + remainder == dividend, and remainder < divisor.
// - No overflow is possible, because the quotient is N_W wide.
// - divisor==1: quotient=dividend, remainder=0.
// - dividend < divisor: quotient=0, remainder=dividend[D_W-1:0].
// TESTING
// - 1000 / 7: done 33 cycles after start; quotient=142, remainder=6, div_zero=0.
// - 0xFFFF_FFFE / 0xFFFF: quotient=0x0001_0000, remainder=0xFFFE.
// - Round-trip with the multiplier: 699678 (1234*567) / 567 gives quotient=1234,
//   remainder=0. Sweep 1000 random a,b with b!=0 and check the results match a exactly.
// - 0x1234 / 0: done one cycle after start; quotient=0xFFFF_FFFF, remainder=0,
//   div_zero=1, busy never high.
// - start pulsed with 50/5 at cycle 10 of an in-progress 1000/7: ignored, and the
//   1000/7 result is still returned.
// - rst asserted at cycle 15 of an operation: all outputs are 0 next cycle, and no done
//   follows. A new 9/4 then gives quotient=2, remainder=1.

Source files
------------

// File: rtl/divide_seq_if.sv
// Start/done handshake and result bus between the operation decoder
// and the iterative divider.
interface divide_seq_if #(
    parameter int N_W = 32,
    parameter int D_W = 16
);
    logic           start;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/divide_seq.sv
// Iterative restoring divider: one quotient bit per cycle, N_W cycles,
// with a single-cycle shortcut for a zero divisor.
module divide_seq #(
    parameter int N_W = 32,
    parameter int D_W = 16
) (
    input logic        clk,
    input logic        rst,
    divide_seq_if.slave bus
);
    localparam int C_W = (N_W > 1) ? $clog2(N_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t         state, state_nx;
    logic [N_W-1:0] work, work_nx;
    logic [D_W-1:0] dvr, dvr_nx;
    logic [D_W:0]   pr, pr_nx;
    logic [C_W-1:0] cnt, cnt_nx;
    logic           busy, busy_nx;
    logic           done, done_nx;
    logic [N_W-1:0] quo, quo_nx;
    logic [D_W-1:0] rem, rem_nx;
    logic           dz, dz_nx;

    logic [D_W:0]   shifted;
    logic           ge;
    logic [D_W:0]   pr_step;
    logic [N_W-1:0] work_step;

    // work shifts dividend bits out at the top and quotient bits in at the bottom
    assign shifted   = {pr[D_W-1:0], work[N_W-1]};
    assign ge        = shifted >= {1'b0, dvr};
    assign pr_step   = ge ? shifted - {1'b0, dvr} : shifted;
    assign work_step = {work[N_W-2:0], ge};

    always_comb begin
        state_nx = state;
        work_nx  = work;
        dvr_nx   = dvr;
        pr_nx    = pr;
        cnt_nx   = cnt;
        busy_nx  = busy;
        done_nx  = 1'b0;
        quo_nx   = quo;
        rem_nx   = rem;
        dz_nx    = dz;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        state_nx = CALC;
                        work_nx  = bus.dividend;
                        dvr_nx   = bus.divisor;
                        pr_nx    = '0;
                        cnt_nx   = C_W'(N_W - 1);
                        busy_nx  = 1'b1;
                        dz_nx    = 1'b0;
                    end else begin
                        state_nx = FIN;
                        quo_nx   = '1;
                        rem_nx   = '0;
                        dz_nx    = 1'b1;
                        done_nx  = 1'b1;
                    end
                end
            end
            CALC: begin
                pr_nx   = pr_step;
                work_nx = work_step;
                cnt_nx  = cnt - 1'b1;
                if (cnt == '0) begin
                    state_nx = FIN;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    quo_nx   = work_step;
                    rem_nx   = pr_step[D_W-1:0];
                end
            end
            FIN: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            dvr   <= '0;
            pr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            dvr   <= dvr_nx;
            pr    <= pr_nx;
            cnt   <= cnt_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            quo   <= quo_nx;
            rem   <= rem_nx;
            dz    <= dz_nx;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.quotient  = quo;
    assign bus.remainder = rem;
    assign bus.div_zero  = dz;
endmodule

// File: tb/tb_divide_seq.sv
// Directed and sweep checks for divide_seq: latency, results,
// divide-by-zero, ignored starts, back-to-back and mid-operation reset.
module tb_divide_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    divide_seq_if #(.N_W(32), .D_W(16)) bus ();

    divide_seq #(.N_W(32), .D_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Launches one divide and waits (bounded) for done.
    task automatic run_div(
        input  logic [31:0] a,
        input  logic [15:0] b,
        output int          lat,
        output int          bcnt
    );
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.busy) bcnt++;
        end while (!bus.done && lat < 100);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done got=%b want=0", bus.done);
        end
        n_cmp++;
        if (bus.quotient !== 32'h0 || bus.remainder !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_results got q=%h r=%h want 0",
                     bus.quotient, bus.remainder);
        end
        n_cmp++;
        if (bus.div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_dz got=%b want=0", bus.div_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run_div(32'd1000, 16'd7, lat, bcnt);
        n_cmp++;
        if (lat !== 33) begin
            n_bad++;
            $display("FAIL basic_latency got=%0d want=33", lat);
        end
        n_cmp++;
        if (bcnt !== 32) begin
            n_bad++;
            $display("FAIL basic_busy_cycles got=%0d want=32", bcnt);
        end
        n_cmp++;
        if (bus.quotient !== 32'd142 || bus.remainder !== 16'd6) begin
            n_bad++;
            $display("FAIL basic_1000_7 got q=%0d r=%0d want q=142 r=6",
                     bus.quotient, bus.remainder);
        end
        n_cmp++;
        if (bus.div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_dz got=%b want=0", bus.div_zero);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse got=%b want=0", bus.done);
        end
        n_cmp++;
        if (bus.quotient !== 32'd142 || bus.remainder !== 16'd6) begin
            n_bad++;
            $display("FAIL result_hold got q=%0d r=%0d want q=142 r=6",
                     bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_max();
        int lat, bcnt;
        run_div(32'hFFFF_FFFE, 16'hFFFF, lat, bcnt);
        n_cmp++;
        if (bus.quotient !== 32'h0001_0000 || bus.remainder !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL max_div got q=%h r=%h want q=00010000 r=fffe",
                     bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_boundary();
        int lat, bcnt;
        run_div(32'hDEAD_BEEF, 16'd1, lat, bcnt);
        n_cmp++;
        if (bus.quotient !== 32'hDEAD_BEEF || bus.remainder !== 16'h0) begin
            n_bad++;
            $display("FAIL div_by_one got q=%h r=%h want q=deadbeef r=0",
                     bus.quotient, bus.remainder);
        end
        run_div(32'd5, 16'd9, lat, bcnt);
        n_cmp++;
        if (bus.quotient !== 32'd0 || bus.remainder !== 16'd5) begin
            n_bad++;
            $display("FAIL small_dividend got q=%0d r=%0d want q=0 r=5",
                     bus.quotient, bus.remainder);
        end
        run_div(32'd0, 16'd5, lat, bcnt);
        n_cmp++;
        if (bus.quotient !== 32'd0 || bus.remainder !== 16'd0) begin
            n_bad++;
            $display("FAIL zero_dividend got q=%0d r=%0d want 0 0",
                     bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_roundtrip();
        int lat, bcnt;
        logic [15:0] a, b;
        run_div(32'd699678, 16'd567, lat, bcnt);
        n_cmp++;
        if (bus.quotient !== 32'd1234 || bus.remainder !== 16'd0) begin
            n_bad++;
            $display("FAIL rt_1234x567 got q=%0d r=%0d want q=1234 r=0",
                     bus.quotient, bus.remainder);
        end
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom_range(1, 65535));
            run_div(32'(a) * 32'(b), b, lat, bcnt);
            n_cmp++;
            if (lat !== 33 || bus.quotient !== 32'(a) ||
                bus.remainder !== 16'h0) begin
                n_bad++;
                $display("FAIL rt_sweep a=%0d b=%0d got q=%0d r=%0d lat=%0d want q=%0d r=0 lat=33",
                         a, b, bus.quotient, bus.remainder, lat, a);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        run_div(32'h1234, 16'd0, lat, bcnt);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL dz_latency got=%0d want=1", lat);
        end
        n_cmp++;
        if (bcnt !== 0) begin
            n_bad++;
            $display("FAIL dz_busy got=%0d want=0", bcnt);
        end
        n_cmp++;
        if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 16'h0 ||
            bus.div_zero !== 1'b1) begin
            n_bad++;
            $display("FAIL dz_results got q=%h r=%h dz=%b want ffffffff 0 1",
                     bus.quotient, bus.remainder, bus.div_zero);
        end
        run_div(32'd10, 16'd3, lat, bcnt);
        n_cmp++;
        if (bus.quotient !== 32'd3 || bus.remainder !== 16'd1 ||
            bus.div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL dz_clear got q=%0d r=%0d dz=%b want 3 1 0",
                     bus.quotient, bus.remainder, bus.div_zero);
        end
    endtask

    task automatic test_ignore();
        int lat = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 16'd7;
        do begin
            @(negedge clk);
            lat++;
            bus.start = (lat == 10);
            if (lat == 10) begin
                bus.dividend = 32'd50;
                bus.divisor  = 16'd5;
            end
        end while (!bus.done && lat < 100);
        n_cmp++;
        if (lat !== 33 || bus.quotient !== 32'd142 ||
            bus.remainder !== 16'd6) begin
            n_bad++;
            $display("FAIL ignore_start got q=%0d r=%0d lat=%0d want 142 6 33",
                     bus.quotient, bus.remainder, lat);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        int first = 0;
        int second = 0;
        logic [31:0] q1;
        logic [15:0] r1;
        q1 = '0;
        r1 = '0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 16'd10;
        do begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                if (first == 0) begin
                    first = lat;
                    q1 = bus.quotient;
                    r1 = bus.remainder;
                    bus.dividend = 32'd81;
                    bus.divisor  = 16'd9;
                end else begin
                    second = lat;
                end
            end
        end while (second == 0 && lat < 150);
        bus.start = 1'b0;
        n_cmp++;
        if (first !== 33 || q1 !== 32'd10 || r1 !== 16'd0) begin
            n_bad++;
            $display("FAIL b2b_first got q=%0d r=%0d lat=%0d want 10 0 33",
                     q1, r1, first);
        end
        n_cmp++;
        if (second !== 67 || bus.quotient !== 32'd9 ||
            bus.remainder !== 16'd0) begin
            n_bad++;
            $display("FAIL b2b_second got q=%0d r=%0d lat=%0d want 9 0 67",
                     bus.quotient, bus.remainder, second);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        int dseen = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 16'd7;
        repeat (15) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.quotient !== 32'h0 || bus.remainder !== 16'h0 ||
            bus.div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset got b=%b d=%b q=%h r=%h dz=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder,
                     bus.div_zero);
        end
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) dseen++;
        end
        n_cmp++;
        if (dseen !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_abort got=%0d active cycles want=0", dseen);
        end
        run_div(32'd9, 16'd4, lat, bcnt);
        n_cmp++;
        if (bus.quotient !== 32'd2 || bus.remainder !== 16'd1) begin
            n_bad++;
            $display("FAIL after_reset got q=%0d r=%0d want q=2 r=1",
                     bus.quotient, bus.remainder);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_boundary();
        test_div_zero();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_roundtrip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
